cfg_stream_loader: RTL and testbench

- Parametrised serial configuration loader for CGRA tiles.
- Deserialises framed bitstreams (tile ID, word count, start address, payload) from a daisy-chained serial line.
- Writes payload words into the tile's local config memory when the ID matches this tile or the broadcast ID.
- Forwards every bit unchanged to the next tile with fixed 1-cycle latency; sits between the chain input and the tile config RAM.

---
 rtl/cfg_stream_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_cfg_stream_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader
//   Serial configuration loader for one CGRA tile. Deserialises framed
//   bitstreams (ID, LEN, ADDR, LEN x DATA words, each field MSB first) from
//   a daisy-chained serial line and writes the payload into the tile's local
//   config memory when the frame ID matches TILE_ID or BCAST_ID. Every
//   input bit is forwarded unchanged to the next tile with 1-cycle latency.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_ser_in         serial data, MSB first per field
//   i_ser_valid      high for the whole frame; i_ser_in sampled only then
//   o_ser_out        i_ser_in registered (to next tile)
//   o_ser_out_valid  i_ser_valid registered (to next tile)
//   o_mem_we         one-cycle write strobe
//   o_mem_addr       write address, valid with o_mem_we
//   o_mem_wdata      write data, valid with o_mem_we
//   o_frame_done     one-cycle pulse when a matching frame completes
//   o_busy           high whenever the FSM is not IDLE
//   o_err            sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module cfg_stream_loader #(
  parameter int                TILE_ID  = 0,
  parameter int                ID_W     = 8,
  parameter logic [ID_W-1:0]   BCAST_ID = 8'hFF,
  parameter int                LEN_W    = 12,
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ser_in,
  input  logic              i_ser_valid,
  output logic              o_ser_out,
  output logic              o_ser_out_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int MAX_HL = (ID_W   > LEN_W)  ? ID_W   : LEN_W;
  localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAXW   = (MAX_HL > MAX_AD) ? MAX_HL : MAX_AD;
  localparam int CNT_W  = $clog2(MAXW + 1);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(TILE_ID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ID,
    S_HDR_LEN,
    S_HDR_ADDR,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [CNT_W-1:0]    r_cnt;
  logic [MAXW-2:0]     r_shift;
  logic [MAXW-1:0]     w_shift_nx;
  logic                r_match;
  logic [LEN_W-1:0]    r_left;
  logic [ADDR_W-1:0]   r_addr;

  logic [CNT_W-1:0]    w_last_idx;
  logic                w_last;
  logic                w_take;
  logic                w_abort;
  logic [ID_W-1:0]     w_id;

  // Current shift contents with the incoming bit appended; each field is
  // read from its low bits on the cycle its last bit arrives.
  assign w_shift_nx = {r_shift, i_ser_in};
  assign w_last     = (r_cnt == w_last_idx);
  assign w_id       = w_shift_nx[ID_W-1:0];

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // IDLE consumes the first ID bit itself, so it shares the ID field width.
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_ser_valid) begin
          w_state_nx = w_last ? S_HDR_LEN : S_HDR_ID;
        end
      end
      S_HDR_ID: begin
        if (!i_ser_valid)  w_state_nx = S_IDLE;
        else if (w_last)   w_state_nx = S_HDR_LEN;
      end
      S_HDR_LEN: begin
        if (!i_ser_valid)  w_state_nx = S_IDLE;
        else if (w_last)   w_state_nx = S_HDR_ADDR;
      end
      S_HDR_ADDR: begin
        if (!i_ser_valid) begin
          w_state_nx = S_IDLE;
        end else if (w_last) begin
          w_state_nx = (r_match && (r_left != '0)) ? S_DATA : S_DRAIN;
        end
      end
      S_DATA: begin
        if (!i_ser_valid) begin
          w_state_nx = S_IDLE;
        end else if (w_last && (r_left == LEN_W'(1))) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!i_ser_valid)  w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    w_last_idx = '0;
    w_take     = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE, S_HDR_ID: w_last_idx = CNT_W'(ID_W - 1);
      S_HDR_LEN:        w_last_idx = CNT_W'(LEN_W - 1);
      S_HDR_ADDR:       w_last_idx = CNT_W'(ADDR_W - 1);
      S_DATA:           w_last_idx = CNT_W'(DATA_W - 1);
      default:          w_last_idx = '0;
    endcase
    case (r_state)
      S_HDR_ID, S_HDR_LEN, S_HDR_ADDR, S_DATA: begin
        w_abort = !i_ser_valid;
        w_take  = i_ser_valid;
      end
      S_IDLE:  w_take = i_ser_valid;
      default: w_take = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: forwarding, field capture, write strobes, error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ser_out       <= 1'b0;
      o_ser_out_valid <= 1'b0;
      o_mem_we        <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_wdata     <= '0;
      o_frame_done    <= 1'b0;
      o_err           <= 1'b0;
      r_cnt           <= '0;
      r_shift         <= '0;
      r_match         <= 1'b0;
      r_left          <= '0;
      r_addr          <= '0;
    end else begin
      o_ser_out       <= i_ser_in;
      o_ser_out_valid <= i_ser_valid;
      o_mem_we        <= 1'b0;
      o_frame_done    <= 1'b0;

      if (w_abort) begin
        // Partial word is dropped; words already written stay written.
        o_err <= 1'b1;
        r_cnt <= '0;
      end else if (w_take) begin
        r_shift <= w_shift_nx[MAXW-2:0];
        if (w_last) begin
          r_cnt <= '0;
          case (r_state)
            S_IDLE, S_HDR_ID: begin
              r_match <= (w_id == MY_ID) || (w_id == BCAST_ID);
            end
            S_HDR_LEN: begin
              r_left <= w_shift_nx[LEN_W-1:0];
            end
            S_HDR_ADDR: begin
              r_addr <= w_shift_nx[ADDR_W-1:0];
              if (r_match && (r_left == '0)) begin
                o_frame_done <= 1'b1;
              end
            end
            S_DATA: begin
              o_mem_we    <= 1'b1;
              o_mem_wdata <= w_shift_nx[DATA_W-1:0];
              o_mem_addr  <= r_addr;
              r_addr      <= r_addr + ADDR_W'(1);
              r_left      <= r_left - LEN_W'(1);
              if (r_left == LEN_W'(1)) begin
                o_frame_done <= 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_stream_loader
//   Directed bench for cfg_stream_loader with TILE_ID=3 and default widths
//   (ID 8, LEN 12, ADDR 12, DATA 8). Inputs change on the falling edge and
//   outputs are observed on the falling edge, one tick per rising edge.
// ---------------------------------------------------------------------------
module tb_cfg_stream_loader;

  logic        clk;
  logic        rst_n;
  logic        ser_in;
  logic        ser_valid;
  logic        ser_out;
  logic        ser_out_valid;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        frame_done;
  logic        busy;
  logic        err;

  cfg_stream_loader #(
    .TILE_ID (3),
    .ID_W    (8),
    .BCAST_ID(8'hFF),
    .LEN_W   (12),
    .ADDR_W  (12),
    .DATA_W  (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ser_in       (ser_in),
    .i_ser_valid    (ser_valid),
    .o_ser_out      (ser_out),
    .o_ser_out_valid(ser_out_valid),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_frame_done   (frame_done),
    .o_busy         (busy),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          cyc    = 0;
  int          f0     = 0;
  logic        prev_b = 1'b0;
  logic        prev_v = 1'b0;

  logic [11:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  int          fd_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe the result of the previous rising edge, then drive.
  task automatic tick(input logic b, input logic v);
    @(negedge clk);
    cyc++;
    chk("fwd", 32'({ser_out_valid, ser_out}), 32'({prev_v, prev_b}));
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    ser_in    = b;
    ser_valid = v;
    prev_b    = b;
    prev_v    = v;
  endtask

  task automatic send_field(input logic [31:0] val, input int w);
    for (int i = w - 1; i >= 0; i--) tick(val[i], 1'b1);
  endtask

  task automatic send_hdr(input logic [7:0] id, input logic [11:0] len, input logic [11:0] addr);
    f0 = cyc + 1;
    send_field(32'(id), 8);
    send_field(32'(len), 12);
    send_field(32'(addr), 12);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    fd_cyc.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({ser_out, ser_out_valid, mem_we, frame_done, busy, err}), 32'd0);
    chk("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Matching frame, two words
    clear_log();
    send_hdr(8'd3, 12'd2, 12'h010);
    send_field(32'hA5, 8);
    send_field(32'h3C, 8);
    idle(2);
    chk("t1_nwr", wq_addr.size(), 2);
    chk("t1_w0", 32'({wq_addr[0], wq_data[0]}), 32'h010A5);
    chk("t1_w1", 32'({wq_addr[1], wq_data[1]}), 32'h0113C);
    chk("t1_gap", wq_cyc[1] - wq_cyc[0], 8);
    chk("t1_latency", wq_cyc[0] - f0, 40);
    chk("t1_nfd", fd_cyc.size(), 1);
    chk("t1_fd_with_wr", fd_cyc[0], wq_cyc[1]);
    chk("t1_idle", 32'({busy, err}), 32'd0);

    // Non-matching frame, LEN=4
    clear_log();
    send_hdr(8'd5, 12'd4, 12'h100);
    for (int w = 0; w < 4; w++) send_field(32'h5A + w, 8);
    chk("t2_busy_valid", 32'(busy), 32'd1);
    idle(1);
    chk("t2_busy_hold", 32'(busy), 32'd1);
    idle(1);
    chk("t2_busy_drop", 32'(busy), 32'd0);
    chk("t2_nwr", wq_addr.size(), 0);
    chk("t2_nfd", fd_cyc.size(), 0);

    // Broadcast, single word at top address
    clear_log();
    send_hdr(8'hFF, 12'd1, 12'hFFF);
    send_field(32'h81, 8);
    idle(2);
    chk("t3a_nwr", wq_addr.size(), 1);
    chk("t3a_w0", 32'({wq_addr[0], wq_data[0]}), 32'hFFF81);
    chk("t3a_nfd", fd_cyc.size(), 1);

    // Broadcast, address wraps
    clear_log();
    send_hdr(8'hFF, 12'd2, 12'hFFF);
    send_field(32'h12, 8);
    send_field(32'h34, 8);
    idle(2);
    chk("t3b_nwr", wq_addr.size(), 2);
    chk("t3b_w0", 32'({wq_addr[0], wq_data[0]}), 32'hFFF12);
    chk("t3b_w1_wrap", 32'({wq_addr[1], wq_data[1]}), 32'h00034);

    // LEN=0 matching frame with trailing extra bits
    clear_log();
    send_hdr(8'd3, 12'd0, 12'h040);
    send_field(32'hB, 4);
    idle(2);
    chk("t5_nwr", wq_addr.size(), 0);
    chk("t5_nfd", fd_cyc.size(), 1);
    chk("t5_fd_time", fd_cyc[0] - f0, 32);
    chk("t5_no_err", 32'({busy, err}), 32'd0);

    // Abort after 1.5 words of a LEN=3 frame
    clear_log();
    send_hdr(8'd3, 12'd3, 12'h020);
    send_field(32'h11, 8);
    send_field(32'h2, 4);
    idle(1);
    chk("t4_err_pending", 32'(err), 32'd0);
    idle(1);
    chk("t4_err_set", 32'({busy, err}), 32'b01);
    idle(1);
    chk("t4_nwr", wq_addr.size(), 1);
    chk("t4_w0", 32'({wq_addr[0], wq_data[0]}), 32'h02011);
    chk("t4_nfd", fd_cyc.size(), 0);

    clear_log();
    send_hdr(8'd3, 12'd1, 12'h030);
    send_field(32'h5A, 8);
    idle(2);
    chk("t4b_w0", 32'({wq_addr[0], wq_data[0]}), 32'h0305A);
    chk("t4b_nfd", fd_cyc.size(), 1);
    chk("t4b_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-DATA
    clear_log();
    send_hdr(8'd3, 12'd2, 12'h050);
    send_field(32'h77, 8);
    send_field(32'h5, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'({ser_out, ser_out_valid, mem_we, frame_done, busy, err}), 32'd0);
    chk("t6_async_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    prev_b = 1'b0;
    prev_v = 1'b0;
    idle(1);
    clear_log();
    send_hdr(8'd3, 12'd1, 12'h060);
    send_field(32'hC3, 8);
    idle(2);
    chk("t6_nwr", wq_addr.size(), 1);
    chk("t6_w0", 32'({wq_addr[0], wq_data[0]}), 32'h060C3);
    chk("t6_nfd", fd_cyc.size(), 1);
    chk("t6_latency", wq_cyc[0] - f0, 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
